// File: rtl/arb_pkg.sv
// Shared types and constants for the arbitrage detector.
// Holds the FSM encoding, default price width and trade direction codes.
package arb_pkg;

    localparam int PRICE_W_DEF = 16;

    localparam logic DIR_BUY_A = 1'b0;
    localparam logic DIR_BUY_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_FIRE = 2'd2,
        ST_COOL = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_spread.sv
// Absolute price difference and trade direction of two prices.
// Uses a one-bit-wider subtraction so the borrow selects the direction.
module arb_spread
    import arb_pkg::*;
#(
    parameter int PRICE_W = PRICE_W_DEF
) (
    input  logic [PRICE_W-1:0] a,
    input  logic [PRICE_W-1:0] b,
    output logic [PRICE_W-1:0] spread,
    output logic               dir
);

    logic [PRICE_W:0] diff;

    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        if (diff[PRICE_W]) begin
            spread = b - a;
            dir    = DIR_BUY_A;
        end else begin
            spread = diff[PRICE_W-1:0];
            dir    = (diff != '0) ? DIR_BUY_B : DIR_BUY_A;
        end
    end

endmodule

// File: rtl/arbitrage_detector.sv
// Two-exchange arbitrage detector: latch, evaluate, fire, cool down.
// Define ARB_STATS_EN to build the trade_count / max_spread statistics.
module arbitrage_detector
    import arb_pkg::*;
#(
    parameter int PRICE_W         = PRICE_W_DEF,
    parameter int THRESHOLD       = 5,
    parameter int COOLDOWN_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRICE_W-1:0] price_A,
    input  logic [PRICE_W-1:0] price_B,
    input  logic               packet_valid,
    output logic               trade_valid,
    output logic               trade_dir,
    output logic [PRICE_W-1:0] buy_price,
    output logic [PRICE_W-1:0] sell_price,
    output logic [PRICE_W-1:0] trade_spread,
    output logic               busy,
    output logic [15:0]        trade_count,
    output logic [PRICE_W-1:0] max_spread
);

    localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [PRICE_W-1:0] THR = PRICE_W'(THRESHOLD);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [PRICE_W-1:0] lat_a;
    logic [PRICE_W-1:0] lat_b;
    logic [CNT_W-1:0]   cd_cnt;
    logic [PRICE_W-1:0] spread;
    logic               dir;
    logic               fire_ok;

    arb_spread #(
        .PRICE_W (PRICE_W)
    ) u_spread (
        .a      (lat_a),
        .b      (lat_b),
        .spread (spread),
        .dir    (dir)
    );

    assign fire_ok = (spread > THR) &&
                     (lat_a != '0) &&
                     (lat_b != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (packet_valid) state_nxt = ST_EVAL;
            ST_EVAL: state_nxt = fire_ok ? ST_FIRE : ST_IDLE;
            ST_FIRE: state_nxt = ST_COOL;
            ST_COOL: if (cd_cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        trade_valid = (state == ST_FIRE);
        busy        = (state != ST_IDLE);
    end

    // Trade fields load only on a firing evaluation and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_a        <= '0;
            lat_b        <= '0;
            cd_cnt       <= '0;
            trade_dir    <= DIR_BUY_A;
            buy_price    <= '0;
            sell_price   <= '0;
            trade_spread <= '0;
        end else begin
            if (state == ST_IDLE && packet_valid) begin
                lat_a <= price_A;
                lat_b <= price_B;
            end
            if (state == ST_EVAL && fire_ok) begin
                trade_dir    <= dir;
                buy_price    <= dir ? lat_b : lat_a;
                sell_price   <= dir ? lat_a : lat_b;
                trade_spread <= spread;
            end
            if (state == ST_FIRE) begin
                cd_cnt <= CNT_LOAD;
            end else if (state == ST_COOL && cd_cnt != '0) begin
                cd_cnt <= cd_cnt - 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0]        cnt_q;
    logic [PRICE_W-1:0] max_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            max_q <= '0;
        end else if (state == ST_FIRE) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
            if (trade_spread > max_q) max_q <= trade_spread;
        end
    end

    assign trade_count = cnt_q;
    assign max_spread  = max_q;
`else
    assign trade_count = '0;
    assign max_spread  = '0;
`endif

endmodule

// File: tb/tb_arbitrage_detector.sv
// Testbench for arbitrage_detector: directed cases plus random packets
// checked against a transaction-level timing/price model.
module tb_arbitrage_detector;

    localparam int PW  = 16;
    localparam int THR = 5;
    localparam int CD  = 8;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic          pv;
    logic          trade_valid;
    logic          trade_dir;
    logic [PW-1:0] buy_price;
    logic [PW-1:0] sell_price;
    logic [PW-1:0] trade_spread;
    logic          busy;
    logic [15:0]   trade_count;
    logic [PW-1:0] max_spread;

    always #10 clk = ~clk;

    arbitrage_detector #(
        .PRICE_W         (PW),
        .THRESHOLD       (THR),
        .COOLDOWN_CYCLES (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .price_A      (pa),
        .price_B      (pb),
        .packet_valid (pv),
        .trade_valid  (trade_valid),
        .trade_dir    (trade_dir),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .trade_spread (trade_spread),
        .busy         (busy),
        .trade_count  (trade_count),
        .max_spread   (max_spread)
    );

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int free_cyc = 0;
    int fire_cyc = -100;
    int busy_lo = -100;
    int busy_hi = -100;
    int e_dir, e_buy, e_sell, e_spr, e_cnt, e_max;
    int p_dir, p_buy, p_sell, p_spr;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        free_cyc = cyc;
        fire_cyc = -100;
        busy_lo  = -100;
        busy_hi  = -100;
        e_dir = 0; e_buy = 0; e_sell = 0; e_spr = 0;
        e_cnt = 0; e_max = 0;
    endtask

    task automatic check_all();
        if (cyc == fire_cyc) begin
            e_dir  = p_dir;
            e_buy  = p_buy;
            e_sell = p_sell;
            e_spr  = p_spr;
        end
        if (STATS && cyc == fire_cyc + 1) begin
            if (e_cnt < 65535) e_cnt++;
            if (e_spr > e_max) e_max = e_spr;
        end
        check("trade_valid", 32'(trade_valid), (cyc == fire_cyc) ? 1 : 0);
        check("busy", 32'(busy),
              (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        check("trade_dir", 32'(trade_dir), e_dir);
        check("buy_price", 32'(buy_price), e_buy);
        check("sell_price", 32'(sell_price), e_sell);
        check("trade_spread", 32'(trade_spread), e_spr);
        check("trade_count", 32'(trade_count), e_cnt);
        check("max_spread", 32'(max_spread), e_max);
    endtask

    // Packet accepted only when the model says the block is idle.
    task automatic model_accept(input logic [PW-1:0] a,
                                input logic [PW-1:0] b);
        int ia, ib, d;
        ia = int'(a);
        ib = int'(b);
        if (cyc < free_cyc) return;
        d = (ia > ib) ? ia - ib : ib - ia;
        if (d > THR && ia != 0 && ib != 0) begin
            p_dir    = (ib < ia) ? 1 : 0;
            p_buy    = (ia < ib) ? ia : ib;
            p_sell   = (ia < ib) ? ib : ia;
            p_spr    = d;
            fire_cyc = cyc + 2;
            busy_lo  = cyc + 1;
            busy_hi  = cyc + 2 + CD;
            free_cyc = cyc + 3 + CD;
        end else begin
            busy_lo  = cyc + 1;
            busy_hi  = cyc + 1;
            free_cyc = cyc + 2;
        end
    endtask

    task automatic step(input logic v,
                        input logic [PW-1:0] a,
                        input logic [PW-1:0] b);
        check_all();
        pv = v;
        pa = a;
        pb = b;
        if (v) model_accept(a, b);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic mid_reset();
        check_all();
        pv  = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pv  = 1'b0;
        pa  = '0;
        pb  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b1;
        idle(3);

        step(1'b1, 16'd100, 16'd110);
        idle(14);

        step(1'b1, 16'd200, 16'd195);
        idle(3);
        step(1'b1, 16'd200, 16'd194);
        idle(14);

        step(1'b1, 16'd0, 16'd50);
        idle(3);
        step(1'b1, 16'hFFFF, 16'd0);
        idle(3);
        step(1'b1, 16'hFFFF, 16'd1);
        idle(14);
        check("no_wrap_spread", 32'(trade_spread), 32'hFFFE);

        step(1'b1, 16'd100, 16'd110);
        idle(4);
        step(1'b1, 16'd10, 16'd90);
        idle(4);
        step(1'b1, 16'd10, 16'd90);
        step(1'b1, 16'd300, 16'd220);
        idle(14);
        check("after_cooldown_buy", 32'(buy_price), 32'd220);

        step(1'b1, 16'd100, 16'd110);
        step(1'b0, '0, '0);
        mid_reset();
        idle(15);

        step(1'b1, 16'd100, 16'd110);
        idle(12);
        step(1'b1, 16'd50, 16'd43);
        idle(12);
        check("stats_count", 32'(trade_count), STATS ? 32'd2 : 32'd0);
        check("stats_max", 32'(max_spread), STATS ? 32'd10 : 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic          v;
            logic [PW-1:0] a;
            logic [PW-1:0] b;
            v = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 7) == 0) ? '0 :
                PW'($urandom_range(1, 40));
            b = ($urandom_range(0, 7) == 0) ? '0 :
                PW'($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
            step(v, a, b);
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/arbitrage_detector.md
ARBITRAGE_DETECTOR -- requirements
Module: arbitrage_detector

Interface
REQ-001 Parameter PRICE_W, default 16: width of all price and spread values.
REQ-002 Parameter THRESHOLD, default 5: minimum spread, exclusive, that triggers a trade.
REQ-003 Parameter COOLDOWN_CYCLES, default 1000: idle cycles enforced after each trade; legal range is 1 or greater.
REQ-004 Port clk, input, 1: 50 MHz system clock.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port price_A, input, PRICE_W: exchange A price from packet parser.
REQ-007 Port price_B, input, PRICE_W: exchange B price from packet parser.
REQ-008 Port packet_valid, input, 1: one-cycle strobe; prices valid in the same cycle.
REQ-009 Port trade_valid, output, 1: one-cycle trade strobe.
REQ-010 Port trade_dir, output, 1: 0 = buy A/sell B; 1 = buy B/sell A.
REQ-011 Port buy_price / sell_price, output, PRICE_W each: the cheaper and dearer price of the triggering pair.
REQ-012 Port trade_spread, output, PRICE_W: sell_price minus buy_price.
REQ-013 Port busy, output, 1: high in EVAL, FIRE and COOLDOWN.
REQ-014 Port trade_count, output, 16: number of trades issued; saturates at 16'hFFFF.
REQ-015 Port max_spread, output, PRICE_W: largest trade_spread issued since reset.

Function
REQ-016 The FSM SHALL have four states: IDLE, EVAL, FIRE and COOLDOWN.
REQ-017 In IDLE with packet_valid high at edge N, the block SHALL latch both prices and go to EVAL.
REQ-018 In EVAL, the block SHALL register |A-B| using a PRICE_W+1-bit subtraction, plus direction; dir = 1 iff B < A.
REQ-019 Transition out of EVAL at edge N+1:
- Go to FIRE iff spread > THRESHOLD and both prices are nonzero.
- Otherwise return to IDLE.
REQ-020 In FIRE:
- trade_valid SHALL be high for exactly one cycle, with trade_dir, buy_price, sell_price and trade_spread valid in that cycle.
- Latency is packet_valid at edge N to trade_valid high in cycle N+2.
REQ-021 trade_dir, buy_price, sell_price and trade_spread SHALL hold their values until the next FIRE.
REQ-022 FIRE SHALL go to COOLDOWN.
REQ-023 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, counted by a down-counter, then go to IDLE.
REQ-024 packet_valid in EVAL, FIRE or COOLDOWN SHALL be discarded: no latch, no trade, no queueing.
REQ-025 Boundary cases:
- spread == THRESHOLD: no trade.
- Equal prices: no trade.
- A zero price: no trade.
REQ-026 packet_valid arriving in the same cycle the COOLDOWN counter expires SHALL be discarded; the block accepts packets from the following cycle onward.

Reset
REQ-027 On rst low, regardless of clk, the block SHALL set:
- FSM to IDLE and cooldown counter to 0.
- All outputs and latched prices to 0.
REQ-028 Reset mid-EVAL, FIRE or COOLDOWN SHALL abort the sequence; no trade_valid is emitted after reset release until a new packet arrives.

Configuration
REQ-029 Macro ARB_STATS_EN selects statistics behaviour.
REQ-030 With ARB_STATS_EN defined:
- trade_count SHALL increment, saturating, in each FIRE cycle.
- max_spread SHALL update in the FIRE cycle when trade_spread exceeds the stored value.
REQ-031 Without ARB_STATS_EN, trade_count and max_spread ports SHALL exist and be constant 0, with no statistics registers.

Structure
REQ-032 Shared package arb_pkg SHALL hold:
- The FSM state typedef and its encodings.
- The PRICE_W default.
- The DIR_BUY_A / DIR_BUY_B constants.
REQ-033 Sub-module arb_spread SHALL compute the combinational absolute difference and direction of two PRICE_W prices; it is instantiated once.

Verification
All scenarios use THRESHOLD=5 and COOLDOWN_CYCLES=8.
REQ-034 A=100, B=110 strobe -> trade_valid 2 cycles later; dir=0, buy=100, sell=110, spread=10; busy for 1+1+8 cycles.
REQ-035 A=200, B=195 -> no trade (spread 5 equals THRESHOLD); A=200, B=194 -> trade with dir=1, spread=6.
REQ-036 A=0, B=50 -> no trade; A=16'hFFFF, B=0 -> no trade; A=16'hFFFF, B=1 -> trade with spread=16'hFFFE and no wrap.
REQ-037 Trade, then new packet strobes at cooldown cycles 3 and 8 -> both discarded; a strobe 1 cycle after cooldown ends -> evaluated.
REQ-038 rst pulsed low in FIRE cycle -> trade_valid low immediately and all outputs 0; no later trade without a new packet.
REQ-039 With ARB_STATS_EN, trades with spread 10, then 7 -> trade_count=2, max_spread=10; without the macro -> both read 0.
